// File: rtl/dft135_pkg.sv
// Shared types and helpers for the 135-point DFT datapath.
package dft135_pkg;

    localparam int N_DFT   = 135;
    localparam int TW_W    = 18;
    localparam int TW_FRAC = 10;

    typedef struct packed {
        logic signed [TW_W-1:0] re;
        logic signed [TW_W-1:0] im;
    } cplx_t;

    // Round half up by 2^frac, then clamp to a dw-bit signed range.
    function automatic logic signed [63:0] round_sat(
        input  logic signed [63:0] x,
        input  int                 dw,
        input  int                 frac,
        output logic               sat
    );
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        r     = (x + (64'sd1 <<< (frac - 1))) >>> frac;
        max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (dw - 1));
        sat   = 1'b0;
        if (r > max_v) begin
            r   = max_v;
            sat = 1'b1;
        end else if (r < min_v) begin
            r   = min_v;
            sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/twiddle_mult_stage_cmult_pipe.sv
// Three-stage complex multiplier: input register, partial products, round/saturate.
module cmult_pipe
    import dft135_pkg::cplx_t, dft135_pkg::round_sat, dft135_pkg::TW_W;
#(
    parameter int DW      = 18,
    parameter int TW_FRAC = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    input  logic                 in_sof_i,
    input  logic                 in_last_i,
    input  logic                 sat_clr_i,
    input  logic signed [DW-1:0] in_re_i,
    input  logic signed [DW-1:0] in_im_i,
    input  cplx_t                tw_i,
    output logic                 out_valid_o,
    output logic                 out_sof_o,
    output logic                 out_last_o,
    output logic signed [DW-1:0] out_re_o,
    output logic signed [DW-1:0] out_im_o,
    output logic                 sat_flag_o
);
    localparam int PW = DW + TW_W;
    localparam int SW = PW + 1;

    logic                 v1_q, sof1_q, last1_q;
    logic signed [DW-1:0] a_re_q, a_im_q;
    logic                 v2_q, sof2_q, last2_q;
    logic signed [PW-1:0] pp_rr_q, pp_ii_q, pp_ri_q, pp_ir_q;
    logic signed [PW-1:0] pp_rr_d, pp_ii_d, pp_ri_d, pp_ir_d;
    logic signed [SW-1:0] sum_re, sum_im;
    logic signed [DW-1:0] out_re_d, out_im_d;
    logic                 sat_re, sat_im;
    logic                 out_valid_q, out_sof_q, out_last_q, sat_q;
    logic signed [DW-1:0] out_re_q, out_im_q;

    // The twiddle arrives combinationally from the ROM while stage 1 holds the sample.
    assign pp_rr_d = $signed({{TW_W{a_re_q[DW-1]}}, a_re_q}) * $signed({{DW{tw_i.re[TW_W-1]}}, tw_i.re});
    assign pp_ii_d = $signed({{TW_W{a_im_q[DW-1]}}, a_im_q}) * $signed({{DW{tw_i.im[TW_W-1]}}, tw_i.im});
    assign pp_ri_d = $signed({{TW_W{a_re_q[DW-1]}}, a_re_q}) * $signed({{DW{tw_i.im[TW_W-1]}}, tw_i.im});
    assign pp_ir_d = $signed({{TW_W{a_im_q[DW-1]}}, a_im_q}) * $signed({{DW{tw_i.re[TW_W-1]}}, tw_i.re});

    assign sum_re = {pp_rr_q[PW-1], pp_rr_q} - {pp_ii_q[PW-1], pp_ii_q};
    assign sum_im = {pp_ri_q[PW-1], pp_ri_q} + {pp_ir_q[PW-1], pp_ir_q};

    always_comb begin
        sat_re   = 1'b0;
        sat_im   = 1'b0;
        out_re_d = DW'(round_sat({{(64-SW){sum_re[SW-1]}}, sum_re}, DW, TW_FRAC, sat_re));
        out_im_d = DW'(round_sat({{(64-SW){sum_im[SW-1]}}, sum_im}, DW, TW_FRAC, sat_im));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            sof1_q      <= 1'b0;
            last1_q     <= 1'b0;
            a_re_q      <= '0;
            a_im_q      <= '0;
            v2_q        <= 1'b0;
            sof2_q      <= 1'b0;
            last2_q     <= 1'b0;
            pp_rr_q     <= '0;
            pp_ii_q     <= '0;
            pp_ri_q     <= '0;
            pp_ir_q     <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            sat_q       <= 1'b0;
        end else begin
            v1_q    <= in_valid_i;
            sof1_q  <= in_valid_i & in_sof_i;
            last1_q <= in_valid_i & in_last_i;
            if (in_valid_i) begin
                a_re_q <= in_re_i;
                a_im_q <= in_im_i;
            end
            v2_q    <= v1_q;
            sof2_q  <= sof1_q;
            last2_q <= last1_q;
            pp_rr_q <= pp_rr_d;
            pp_ii_q <= pp_ii_d;
            pp_ri_q <= pp_ri_d;
            pp_ir_q <= pp_ir_d;
            out_valid_q <= v2_q;
            out_sof_q   <= sof2_q;
            out_last_q  <= last2_q;
            if (v2_q) begin
                out_re_q <= out_re_d;
                out_im_q <= out_im_d;
            end
            // A saturating sample leaving the pipe outranks a same-cycle frame start.
            if (v2_q && (sat_re || sat_im)) begin
                sat_q <= 1'b1;
            end else if (sat_clr_i) begin
                sat_q <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_sof_o   = out_sof_q;
    assign out_last_o  = out_last_q;
    assign out_re_o    = out_re_q;
    assign out_im_o    = out_im_q;
    assign sat_flag_o  = sat_q;

endmodule

// File: rtl/twiddle_mult_stage.sv
// Inter-stage twiddle multiplier: row/column tracking, twiddle ROM addressing and the multiply pipe.
module twiddle_mult_stage
    import dft135_pkg::cplx_t;
#(
    parameter int DW      = 18,
    parameter int TW_FRAC = 10,
    parameter int R       = 5,
    parameter int C       = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din_valid,
    input  logic                 din_sof,
    input  logic signed [DW-1:0] din_re,
    input  logic signed [DW-1:0] din_im,
    output logic [10:0]          tw_addr,
    input  logic signed [17:0]   tw_re,
    input  logic signed [17:0]   tw_im,
    output logic                 dout_valid,
    output logic                 dout_sof,
    output logic                 dout_last,
    output logic signed [DW-1:0] dout_re,
    output logic signed [DW-1:0] dout_im,
    output logic                 sat_flag
);
    localparam int CW = $clog2(C);
    localparam int RW = $clog2(R);
    localparam int AW = $clog2((R - 1) * (C - 1) + 1);
    localparam logic [CW-1:0] C_LAST  = CW'(C - 1);
    localparam logic [RW-1:0] R_LAST  = RW'(R - 1);
    localparam logic [AW-1:0] ACC_MAX = AW'((R - 1) * (C - 1));

    logic [CW-1:0] c_q, c_d, cur_c;
    logic [RW-1:0] r_q, r_d, cur_r;
    logic [AW-1:0] acc_q, acc_d, cur_acc;
    logic [10:0]   tw_addr_q;
    logic          is_first, is_last;
    cplx_t         tw_s;

    // acc tracks r*c incrementally, so the address needs neither a multiplier nor a modulo.
    always_comb begin
        cur_c   = din_sof ? '0 : c_q;
        cur_r   = din_sof ? '0 : r_q;
        cur_acc = din_sof ? '0 : acc_q;
        c_d     = c_q;
        r_d     = r_q;
        acc_d   = acc_q;
        if (din_valid) begin
            if (cur_c == C_LAST) begin
                c_d   = '0;
                acc_d = '0;
                r_d   = (cur_r == R_LAST) ? '0 : cur_r + RW'(1);
            end else begin
                c_d   = cur_c + CW'(1);
                acc_d = cur_acc + {{(AW-RW){1'b0}}, cur_r};
                r_d   = cur_r;
            end
        end
    end

    assign is_first = (cur_c == '0) && (cur_r == '0);
    assign is_last  = (cur_c == C_LAST) && (cur_r == R_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q       <= '0;
            r_q       <= '0;
            acc_q     <= '0;
            tw_addr_q <= '0;
        end else begin
            c_q   <= c_d;
            r_q   <= r_d;
            acc_q <= acc_d;
            if (din_valid) begin
                tw_addr_q <= {{(11-AW){1'b0}}, cur_acc};
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) acc_q <= ACC_MAX);

    assign tw_addr = tw_addr_q;
    assign tw_s.re = tw_re;
    assign tw_s.im = tw_im;

    cmult_pipe #(
        .DW      (DW),
        .TW_FRAC (TW_FRAC)
    ) u_cmult (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (din_valid),
        .in_sof_i    (is_first),
        .in_last_i   (is_last),
        .sat_clr_i   (din_valid & din_sof),
        .in_re_i     (din_re),
        .in_im_i     (din_im),
        .tw_i        (tw_s),
        .out_valid_o (dout_valid),
        .out_sof_o   (dout_sof),
        .out_last_o  (dout_last),
        .out_re_o    (dout_re),
        .out_im_o    (dout_im),
        .sat_flag_o  (sat_flag)
    );

endmodule
